uart_tx_cfg: RTL and testbench

- Runtime-configurable UART transmitter with an integrated transmit FIFO.
- Successor to the fixed-format transmitter: baud divisor, data width (5-9), parity mode (none/even/odd) and stop bits (1/2) are programmable per frame.
- Adds break generation and back-to-back framing with no idle gap.
- Sits between a CSR/bus-side producer (valid/ready) and the serial TXD pin.

---
 rtl/uart_tx_cfg.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with an integrated transmit FIFO.
// Every frame latches its own word, width, parity, stop count and divisor when
// it leaves the FIFO, so producers may reconfigure at any time without
// corrupting the frame currently on the wire. Frames run back to back with no
// idle gap, and a break request holds TXD low between frames.
module uart_tx_cfg #(
   parameter int MaxDataBits = 9,
   parameter int FifoDepth   = 8,
   parameter int DivWidth    = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DivWidth-1:0]          cfg_div,
   input  logic [3:0]                   cfg_data_bits,
   input  logic [1:0]                   cfg_parity,
   input  logic                         cfg_stop2,
   input  logic                         tx_break,
   input  logic [MaxDataBits-1:0]       data_in,
   input  logic                         data_in_valid,
   output logic                         data_in_ready,
   output logic                         out_bit,
   output logic                         busy,
   output logic [$clog2(FifoDepth):0]   fifo_level
);

   localparam int AW = $clog2(FifoDepth);
   localparam int LW = AW + 1;

   if (MaxDataBits < 5 || MaxDataBits > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: MaxDataBits must lie in [5,9]");
   end
   if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_cfg: FifoDepth must be a power of two and at least 2");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   // Out-of-range widths snap to the nearest legal width.
   function automatic logic [3:0] clamp_bits(input logic [3:0] b);
      if (b < 4'd5)                       return 4'd5;
      else if (b > 4'(MaxDataBits))       return 4'(MaxDataBits);
      else                                return b;
   endfunction

   // Parity covers only the configured low n bits; odd mode inverts.
   function automatic logic parity_bit(input logic [MaxDataBits-1:0] w,
                                       input logic [3:0]             n,
                                       input logic                   odd);
      logic [MaxDataBits-1:0] mask;
      mask = ~({MaxDataBits{1'b1}} << n);
      return (^(w & mask)) ^ odd;
   endfunction

   logic [MaxDataBits-1:0] mem [FifoDepth];
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic                   push, pop, fifo_empty;

   logic [MaxDataBits-1:0] f_word;
   logic [3:0]             f_bits;
   logic                   f_par_en, f_par_odd, f_stop2;
   logic [DivWidth-1:0]    f_div;

   state_t                 state, state_nx;
   logic [DivWidth-1:0]    div_cnt;
   logic [3:0]             bit_idx, bit_idx_nx;
   logic                   stop_cnt, stop_cnt_nx;
   logic                   out_nx;
   logic                   bit_done;
   logic [MaxDataBits-1:0] word_nx_sh;

   assign data_in_ready = (fifo_level != LW'(FifoDepth));
   assign push          = data_in_valid && data_in_ready;
   assign fifo_empty    = (fifo_level == '0);
   assign busy          = (state != IDLE) || !fifo_empty;
   assign bit_done      = (div_cnt == f_div);
   assign word_nx_sh    = f_word >> (bit_idx + 4'd1);

   // FIFO storage: data only, contents are irrelevant once the pointers reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   // FIFO pointers and occupancy; simultaneous push and pop cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Snapshot the head word and the live configuration as a frame starts.
   always_ff @(posedge clk) begin
      if (pop) begin
         f_word    <= mem[rd_ptr];
         f_bits    <= clamp_bits(cfg_data_bits);
         f_par_en  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
         f_par_odd <= (cfg_parity == 2'b10);
         f_stop2   <= cfg_stop2;
         f_div     <= cfg_div;
      end
   end

   // Frame sequencer: next state, next TXD level and the FIFO pop request.
   always_comb begin
      state_nx    = state;
      out_nx      = out_bit;
      bit_idx_nx  = bit_idx;
      stop_cnt_nx = stop_cnt;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            if (tx_break) begin
               state_nx = BREAK;
               out_nx   = 1'b0;
            end else if (!fifo_empty) begin
               pop      = 1'b1;
               state_nx = START;
               out_nx   = 1'b0;
            end else begin
               out_nx   = 1'b1;
            end
         end
         START: begin
            if (bit_done) begin
               state_nx   = DATA;
               bit_idx_nx = '0;
               out_nx     = f_word[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx == f_bits - 4'd1) begin
                  if (f_par_en) begin
                     state_nx = PARITY;
                     out_nx   = parity_bit(f_word, f_bits, f_par_odd);
                  end else begin
                     state_nx    = STOP;
                     stop_cnt_nx = 1'b0;
                     out_nx      = 1'b1;
                  end
               end else begin
                  bit_idx_nx = bit_idx + 4'd1;
                  out_nx     = word_nx_sh[0];
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_nx    = STOP;
               stop_cnt_nx = 1'b0;
               out_nx      = 1'b1;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (f_stop2 && !stop_cnt) begin
                  stop_cnt_nx = 1'b1;
               end else if (tx_break) begin
                  state_nx = BREAK;
                  out_nx   = 1'b0;
               end else if (!fifo_empty) begin
                  // Chain straight into the next start bit, no idle cycle.
                  pop      = 1'b1;
                  state_nx = START;
                  out_nx   = 1'b0;
               end else begin
                  state_nx = IDLE;
                  out_nx   = 1'b1;
               end
            end
         end
         BREAK: begin
            if (!tx_break) begin
               state_nx = IDLE;
               out_nx   = 1'b1;
            end else begin
               out_nx   = 1'b0;
            end
         end
         default: begin
            state_nx = IDLE;
            out_nx   = 1'b1;
         end
      endcase
   end

   // Sequencer state and the registered TXD pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         out_bit  <= 1'b1;
         bit_idx  <= '0;
         stop_cnt <= 1'b0;
      end else begin
         state    <= state_nx;
         out_bit  <= out_nx;
         bit_idx  <= bit_idx_nx;
         stop_cnt <= stop_cnt_nx;
      end
   end

   // Bit-time divider: restarts on every state entry and every bit boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (state_nx != state || bit_done || state == IDLE || state == BREAK) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a queue-based model expands each popped word into its
// per-cycle TXD waveform; a monitor compares the DUT against it every cycle,
// and directed frames are pinned with hand-written bit patterns.
module tb_uart_tx_cfg;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cfg_div = 16'd0;
   logic [3:0]  cfg_data_bits = 4'd8;
   logic [1:0]  cfg_parity = 2'd0;
   logic        cfg_stop2 = 1'b0;
   logic        tx_break = 1'b0;
   logic [8:0]  data_in = 9'd0;
   logic        data_in_valid = 1'b0;
   logic        data_in_ready, out_bit, busy;
   logic [3:0]  fifo_level;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_cfg #(.MaxDataBits(9), .FifoDepth(DEPTH), .DivWidth(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_div       (cfg_div),
      .cfg_data_bits (cfg_data_bits),
      .cfg_parity    (cfg_parity),
      .cfg_stop2     (cfg_stop2),
      .tx_break      (tx_break),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .out_bit       (out_bit),
      .busy          (busy),
      .fifo_level    (fifo_level)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [8:0] mq[$];
   logic       wave[$];
   logic       m_out = 1'b1;
   logic       m_active = 1'b0;
   logic       m_brk = 1'b0;
   logic       m_push;
   logic       mon_en = 1'b0;

   function automatic int clamp_n(input logic [3:0] b);
      if (b < 4'd5) return 5;
      if (b > 4'd9) return 9;
      return int'(b);
   endfunction

   // Expand one frame into its cycle-by-cycle TXD levels.
   task automatic build_frame(input logic [8:0] w);
      int   n;
      int   reps;
      int   ones;
      logic bits[$];
      n    = clamp_n(cfg_data_bits);
      reps = int'(cfg_div) + 1;
      ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         bits.push_back(w[i]);
         ones += int'(w[i]);
      end
      if (cfg_parity == 2'b01)      bits.push_back((ones % 2) == 1);
      else if (cfg_parity == 2'b10) bits.push_back((ones % 2) == 0);
      bits.push_back(1'b1);
      if (cfg_stop2) bits.push_back(1'b1);
      foreach (bits[k])
         for (int r = 0; r < reps; r++) wave.push_back(bits[k]);
   endtask

   task automatic model_step();
      if (rst) begin
         mq.delete();
         wave.delete();
         m_out    = 1'b1;
         m_active = 1'b0;
         m_brk    = 1'b0;
         return;
      end
      m_push = data_in_valid && (mq.size() < DEPTH);
      if (wave.size() > 0) begin
         m_out    = wave.pop_front();
         m_active = 1'b1;
      end else if (m_brk) begin
         if (tx_break) m_out = 1'b0;
         else begin
            m_out    = 1'b1;
            m_brk    = 1'b0;
            m_active = 1'b0;
         end
      end else if (tx_break) begin
         m_brk    = 1'b1;
         m_out    = 1'b0;
         m_active = 1'b1;
      end else if (mq.size() > 0) begin
         build_frame(mq.pop_front());
         m_out    = wave.pop_front();
         m_active = 1'b1;
      end else begin
         m_out    = 1'b1;
         m_active = 1'b0;
      end
      if (m_push) mq.push_back(data_in);
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   // Per-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
         chk("mon_out_bit", int'(out_bit), int'(m_out));
         chk("mon_busy", int'(busy), int'(m_active || (mq.size() != 0)));
         chk("mon_fifo_level", int'(fifo_level), mq.size());
         chk("mon_ready", int'(data_in_ready), int'(mq.size() != DEPTH));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers (called at a falling edge) ----------------
   task automatic send(input logic [8:0] w);
      int n;
      n = 0;
      data_in       = w;
      data_in_valid = 1'b1;
      while (!data_in_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!data_in_ready) chk("send_timeout", 0, 1);
      @(negedge clk);
      data_in_valid = 1'b0;
   endtask

   task automatic wait_low();
      int n;
      n = 0;
      while (out_bit !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (out_bit !== 1'b0) chk("start_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("drain_timeout", 0, 1);
   endtask

   // pat[k] is the k-th bit on the wire, each held reps cycles.
   task automatic check_frame(input string name, input logic [15:0] pat,
                              input int nbits, input int reps);
      for (int i = 0; i < nbits * reps; i++) begin
         chk(name, int'(out_bit), int'(pat[i / reps]));
         @(negedge clk);
      end
   endtask

   int busy_cycles;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_out_bit", int'(out_bit), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_fifo_level", int'(fifo_level), 0);
      chk("rst_ready", int'(data_in_ready), 1);
      rst    = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // 8N1, 4 cycles per bit, 0xA5: 0,1,0,1,0,0,1,0,1,1
      cfg_div = 16'd3; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      send(9'h0A5);
      wait_low();
      check_frame("a5_8n1", 16'h034A, 10, 4);
      chk("a5_busy_after", int'(busy), 0);

      // 7E2, 0x55: 0,1,0,1,0,1,0,1, parity 0, 1,1
      cfg_div = 16'd1; cfg_data_bits = 4'd7; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
      send(9'h055);
      wait_low();
      check_frame("55_7e2", 16'h06AA, 11, 2);
      wait_idle();

      // 7O2, 0x55: parity 1
      cfg_parity = 2'b10;
      send(9'h055);
      wait_low();
      check_frame("55_7o2", 16'h07AA, 11, 2);
      wait_idle();

      // 9O1, one cycle per bit, 0x1FF: 0, nine 1s, parity 0, 1
      cfg_div = 16'd0; cfg_data_bits = 4'd9; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
      send(9'h1FF);
      wait_low();
      check_frame("1ff_9o1", 16'h0BFE, 12, 1);
      wait_idle();

      // Fill the FIFO while break blocks popping, then stream 10 frames.
      cfg_div = 16'd0; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      tx_break = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) send(9'($urandom));
      chk("full_level", int'(fifo_level), 8);
      chk("full_ready", int'(data_in_ready), 0);
      tx_break = 1'b0;
      busy_cycles = 0;
      fork
         begin
            send(9'($urandom));
            send(9'($urandom));
         end
         begin
            @(negedge clk);
            while (busy && busy_cycles < 500) begin
               busy_cycles++;
               @(negedge clk);
            end
         end
      join
      chk("stream_busy_cycles", busy_cycles, 101);

      // Break raised mid-frame with two words queued.
      cfg_div = 16'd1;
      send(9'h013);
      send(9'h0C4);
      send(9'h17E);
      repeat (4) @(negedge clk);
      tx_break = 1'b1;
      repeat (30) @(negedge clk);
      chk("break_out_low", int'(out_bit), 0);
      chk("break_level", int'(fifo_level), 2);
      chk("break_busy", int'(busy), 1);
      tx_break = 1'b0;
      @(negedge clk);
      chk("break_release_high", int'(out_bit), 1);
      @(negedge clk);
      chk("break_next_start", int'(out_bit), 0);
      wait_idle();

      // Asynchronous reset in the middle of the data bits.
      cfg_div = 16'd2;
      send(9'h0F0);
      send(9'h00F);
      send(9'h133);
      wait_low();
      repeat (8) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_bit", int'(out_bit), 1);
      chk("midrst_level", int'(fifo_level), 0);
      chk("midrst_ready", int'(data_in_ready), 1);
      chk("midrst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("postrst_idle_out", int'(out_bit), 1);
      chk("postrst_idle_busy", int'(busy), 0);

      // Randomized configuration, traffic and breaks.
      for (int it = 0; it < 60; it++) begin
         cfg_div       = 16'($urandom_range(0, 3));
         cfg_data_bits = 4'($urandom_range(0, 15));
         cfg_parity    = 2'($urandom_range(0, 3));
         cfg_stop2     = 1'($urandom_range(0, 1));
         send(9'($urandom));
         repeat ($urandom_range(0, 6)) @(negedge clk);
         if ($urandom_range(0, 9) == 0) begin
            tx_break = 1'b1;
            repeat ($urandom_range(1, 12)) @(negedge clk);
            tx_break = 1'b0;
         end
      end
      wait_idle();
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
